ds18b20_temp_sequencer: RTL

//  Command sequencer upstream of the 1-Wire RW data module. Runs one full DS18B20 measurement per START:

---
 rtl/ds18b20_temp_sequencer_pkg.sv | 39 +++
 rtl/ds18b20_temp_sequencer_if.sv | 29 ++
 rtl/ds18b20_temp_sequencer_crc8.sv | 38 +++
 rtl/ds18b20_temp_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ds18b20_temp_sequencer_pkg.sv
// Shared definitions for the DS18B20 measurement sequencer.
// Contents: FSM state encoding, 1-Wire command bytes, the CRC-8 polynomial,
// per-operation bit counts and a single-bit CRC-8 update helper.
package ds18b20_temp_sequencer_pkg;

    // Sequencer states. Bus-operation states are RST1, CMD1, RST2, CMD2 and READ.
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_RST1 = 4'd1;
    localparam logic [3:0] ST_CHK1 = 4'd2;
    localparam logic [3:0] ST_CMD1 = 4'd3;
    localparam logic [3:0] ST_CONV = 4'd4;
    localparam logic [3:0] ST_RST2 = 4'd5;
    localparam logic [3:0] ST_CHK2 = 4'd6;
    localparam logic [3:0] ST_CMD2 = 4'd7;
    localparam logic [3:0] ST_READ = 4'd8;
    localparam logic [3:0] ST_CRC  = 4'd9;
    localparam logic [3:0] ST_DONE = 4'd10;

    // 1-Wire command bytes
    localparam logic [7:0] SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CONVERT_T    = 8'h44;
    localparam logic [7:0] READ_SCRATCH = 8'hBE;

    // Dallas CRC-8, x^8+x^5+x^4+1 in reflected form
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    // Bit counts handed to the RW module
    localparam logic [7:0]  CMD_BITS     = 8'd16;
    localparam logic [7:0]  READ_BITS    = 8'd72;
    localparam int unsigned SCRATCH_BITS = 72;

    // One LSB-first step of the reflected CRC-8
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[0] ^ bit_in;
        return fb ? ((crc >> 1) ^ CRC8_POLY) : (crc >> 1);
    endfunction

endpackage

// File: rtl/ds18b20_temp_sequencer_if.sv
// Command bus between the DS18B20 sequencer and the 1-Wire RW data module.
//  RW             1=read, 0=write
//  DATA_TO_SEND   write payload, bit 0 transmitted first
//  COUNTER        number of bits for the operation
//  ENABLE         operation request
//  INIT           reset/presence request
//  DATA_RECEIVED  read payload, bit 0 = first bit read
//  ONE_WIRE_READY RW module idle when high
//  PRESENCE_OK    presence result, valid once READY returns after an init
interface ds18b20_temp_sequencer_if;
    logic        RW;
    logic [79:0] DATA_TO_SEND;
    logic [7:0]  COUNTER;
    logic        ENABLE;
    logic        INIT;
    logic [79:0] DATA_RECEIVED;
    logic        ONE_WIRE_READY;
    logic        PRESENCE_OK;

    modport master (
        output RW, DATA_TO_SEND, COUNTER, ENABLE, INIT,
        input  DATA_RECEIVED, ONE_WIRE_READY, PRESENCE_OK
    );

    modport slave (
        input  RW, DATA_TO_SEND, COUNTER, ENABLE, INIT,
        output DATA_RECEIVED, ONE_WIRE_READY, PRESENCE_OK
    );
endinterface

// File: rtl/ds18b20_temp_sequencer_crc8.sv
// Serial Dallas CRC-8 (reflected, init 0), one bit per clock, LSB first.
//  clk, rst_n  clock and asynchronous active-low reset
//  clear       synchronous clear to 0 (wins over bit_valid)
//  bit_in      data bit
//  bit_valid   fold bit_in into the CRC this cycle
//  crc         running CRC; 0 after a full block with a valid trailing CRC byte
module onewire_crc8_serial
    import ds18b20_temp_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] crc
);
    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (bit_valid) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
endmodule

// File: rtl/ds18b20_temp_sequencer.sv
// DS18B20 measurement sequencer. One START runs reset/presence, Skip ROM + Convert T,
// conversion wait, reset/presence, Skip ROM + Read Scratchpad, a 72-bit read, then a
// serial CRC check of the scratchpad before publishing the raw temperature.
//  DS_SEQ_CLK, DS_SEQ_RST_N  clock, asynchronous active-low reset
//  START        1-cycle request, ignored while BUSY
//  BUSY         measurement in progress
//  TEMP         raw {byte1,byte0}, updated only on good CRC
//  TEMP_VALID   1-cycle pulse when TEMP updates
//  CRC_ERR      sticky scratchpad CRC failure, cleared by START
//  NO_PRESENCE  sticky missing presence pulse, cleared by START
//  bus          master side of the RW module command bus
module ds18b20_temp_sequencer
    import ds18b20_temp_sequencer_pkg::*;
#(
    parameter int unsigned CONV_WAIT_CYCLES = 3000000,
    parameter int unsigned CONV_CNT_W       = 22
) (
    input  logic                       DS_SEQ_CLK,
    input  logic                       DS_SEQ_RST_N,
    input  logic                       START,
    output logic                       BUSY,
    output logic [15:0]                TEMP,
    output logic                       TEMP_VALID,
    output logic                       CRC_ERR,
    output logic                       NO_PRESENCE,
    ds18b20_temp_sequencer_if.master   bus
);
    localparam logic [CONV_CNT_W-1:0] CONV_LAST = CONV_CNT_W'(CONV_WAIT_CYCLES - 1);
    localparam logic [6:0]            CRC_LAST  = 7'(SCRATCH_BITS - 1);

    logic [3:0]            state_q, state_d;
    logic                  en_q, en_d;       // ENABLE asserted in REQ
    logic                  wait_q, wait_d;   // op in WAIT phase
    logic [CONV_CNT_W-1:0] conv_cnt_q, conv_cnt_d;
    logic [6:0]            bit_cnt_q, bit_cnt_d;
    logic [71:0]           scratch_q, scratch_d;
    logic [15:0]           temp_q, temp_d;
    logic                  temp_valid_q, temp_valid_d;
    logic                  crc_err_q, crc_err_d;
    logic                  no_pres_q, no_pres_d;

    logic       op_state;
    logic       op_done;
    logic       crc_clear;
    logic       crc_bit_valid;
    logic [7:0] crc;

    assign op_state = (state_q == ST_RST1) || (state_q == ST_CMD1) || (state_q == ST_RST2) ||
                      (state_q == ST_CMD2) || (state_q == ST_READ);
    assign op_done  = op_state && wait_q && bus.ONE_WIRE_READY;

    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        wait_d        = wait_q;
        conv_cnt_d    = conv_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        scratch_d     = scratch_q;
        temp_d        = temp_q;
        temp_valid_d  = 1'b0;
        crc_err_d     = crc_err_q;
        no_pres_d     = no_pres_q;
        crc_clear     = 1'b0;
        crc_bit_valid = 1'b0;

        // REQ/WAIT handshake: raise ENABLE only once the RW module is idle, hold it until
        // READY falls, then wait for READY to return.
        if (op_state) begin
            if (!wait_q) begin
                if (!en_q) begin
                    if (bus.ONE_WIRE_READY) en_d = 1'b1;
                end else if (!bus.ONE_WIRE_READY) begin
                    en_d   = 1'b0;
                    wait_d = 1'b1;
                end
            end else if (bus.ONE_WIRE_READY) begin
                wait_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d   = ST_RST1;
                    crc_err_d = 1'b0;
                    no_pres_d = 1'b0;
                    crc_clear = 1'b1;
                end
            end
            ST_RST1: if (op_done) state_d = ST_CHK1;
            ST_CHK1, ST_CHK2: begin
                if (!bus.PRESENCE_OK) begin
                    no_pres_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = (state_q == ST_CHK1) ? ST_CMD1 : ST_CMD2;
                end
            end
            ST_CMD1: begin
                if (op_done) begin
                    state_d    = ST_CONV;
                    conv_cnt_d = '0;
                end
            end
            ST_CONV: begin
                // Counter parks at terminal count rather than wrapping
                if (conv_cnt_q == CONV_LAST) begin
                    state_d = ST_RST2;
                end else begin
                    conv_cnt_d = conv_cnt_q + 1'b1;
                end
            end
            ST_RST2: if (op_done) state_d = ST_CHK2;
            ST_CMD2: if (op_done) state_d = ST_READ;
            ST_READ: begin
                if (op_done) begin
                    scratch_d = bus.DATA_RECEIVED[71:0];
                    bit_cnt_d = '0;
                    state_d   = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_bit_valid = 1'b1;
                if (bit_cnt_q == CRC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // A presence failure skips the read, so the CRC result is meaningless there
                if (!no_pres_q) begin
                    if (crc == 8'h00) begin
                        temp_d       = scratch_q[15:0];
                        temp_valid_d = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge DS_SEQ_CLK or negedge DS_SEQ_RST_N) begin
        if (!DS_SEQ_RST_N) begin
            state_q      <= ST_IDLE;
            en_q         <= 1'b0;
            wait_q       <= 1'b0;
            conv_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            scratch_q    <= '0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            no_pres_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            wait_q       <= wait_d;
            conv_cnt_q   <= conv_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            scratch_q    <= scratch_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            crc_err_q    <= crc_err_d;
            no_pres_q    <= no_pres_d;
        end
    end

    onewire_crc8_serial u_crc (
        .clk       (DS_SEQ_CLK),
        .rst_n     (DS_SEQ_RST_N),
        .clear     (crc_clear),
        .bit_in    (scratch_q[bit_cnt_q]),
        .bit_valid (crc_bit_valid),
        .crc       (crc)
    );

    // Bus outputs decode straight from registered state so reset clears them at once
    always_comb begin
        bus.RW           = (state_q == ST_READ);
        bus.ENABLE       = en_q;
        bus.INIT         = en_q && ((state_q == ST_RST1) || (state_q == ST_RST2));
        bus.COUNTER      = 8'd0;
        bus.DATA_TO_SEND = '0;
        case (state_q)
            ST_CMD1: begin
                bus.COUNTER      = CMD_BITS;
                bus.DATA_TO_SEND = {64'd0, CONVERT_T, SKIP_ROM};
            end
            ST_CMD2: begin
                bus.COUNTER      = CMD_BITS;
                bus.DATA_TO_SEND = {64'd0, READ_SCRATCH, SKIP_ROM};
            end
            ST_READ: bus.COUNTER = READ_BITS;
            default: ;
        endcase
    end

    assign BUSY        = (state_q != ST_IDLE);
    assign TEMP        = temp_q;
    assign TEMP_VALID  = temp_valid_q;
    assign CRC_ERR     = crc_err_q;
    assign NO_PRESENCE = no_pres_q;
endmodule
